quadrature_filter: RTL and testbench

Front-end conditioner for a rotary/quadrature encoder on two raw GPIO input pins. Synchronises and glitch-filters each channel, then decodes 4x quadrature transitions into step/direction pulses and a wrap-around position count. Sits directly upstream of the Murax quadrature peripheral: its filtered `quad_a`/`quad_b` drive the SoC's `io_quadrature_quadA`/`io_quadrature_quadB` in place of the raw pins, and `position`/`error` are available for direct use or debug.

---
 rtl/quadrature_filter_if.sv | 27 ++
 rtl/quadrature_filter.sv | 160 ++++++++++++++++
 tb/tb_quadrature_filter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_filter_if.sv
// Encoder front-end bus: raw pins and clear in, conditioned channels,
// step/direction and position out.
interface quadrature_filter_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   quad_a_pin;
    logic                   quad_b_pin;
    logic                   clear;
    logic                   quad_a;
    logic                   quad_b;
    logic                   step;
    logic                   dir;
    logic [COUNT_WIDTH-1:0] position;
    logic                   error;

    // Side that drives the raw pins and observes the decoded results.
    modport master (
        output quad_a_pin, quad_b_pin, clear,
        input  quad_a, quad_b, step, dir, position, error
    );

    // The conditioner itself.
    modport slave (
        input  quad_a_pin, quad_b_pin, clear,
        output quad_a, quad_b, step, dir, position, error
    );
endinterface

// File: rtl/quadrature_filter.sv
// Quadrature encoder conditioner: two-flop synchroniser and dwell filter per
// channel, followed by a 4x decoder producing step/dir pulses, a wrapping
// signed position count and a sticky illegal-transition flag.
module quadrature_filter #(
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    quadrature_filter_if.slave  bus
);
    localparam int FCW         = $clog2(FILTER_CYCLES + 1);
    // Long enough for a level present at reset to pass the synchroniser and
    // the filter before decoding is enabled.
    localparam int INIT_CYCLES = 2 + FILTER_CYCLES + 1;
    localparam int ICW         = $clog2(INIT_CYCLES + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0] pin_raw;
    logic [1:0] filt;

    assign pin_raw = {bus.quad_a_pin, bus.quad_b_pin};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic           sync1_reg;
            logic           sync2_reg;
            logic           filt_reg;
            logic [FCW-1:0] cnt_reg;
            logic [FCW-1:0] cnt_inc;

            assign cnt_inc  = cnt_reg + FCW'(1);
            assign filt[gi] = filt_reg;

            // Synchronise the pin, then let the filtered level follow only
            // after the new level has held for FILTER_CYCLES clocks.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    filt_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pin_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_inc == FCW'(FILTER_CYCLES)) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
            end
        end
    endgenerate

    state_t                  state_reg, state_next;
    logic [ICW-1:0]          init_cnt_reg, init_cnt_next;
    logic [1:0]              prev_reg;
    logic                    step_reg, step_next;
    logic                    dir_reg, dir_next;
    logic [COUNT_WIDTH-1:0]  pos_reg, pos_next;
    logic                    err_reg, err_next;

    logic fwd;
    logic rev;
    logic illegal;

    // Classify the filtered-level change since last cycle (A is the MSB).
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_reg, filt})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
            default: ;
        endcase
    end

    assign illegal = ((prev_reg ^ filt) == 2'b11);

    // Next state and decoded outputs; clear overrides position and error last.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        step_next     = 1'b0;
        dir_next      = dir_reg;
        pos_next      = pos_reg;
        err_next      = err_reg;

        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == ICW'(INIT_CYCLES - 1)) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + ICW'(1);
                end
            end
            ST_RUN: begin
                if (fwd) begin
                    step_next = 1'b1;
                    dir_next  = 1'b1;
                    pos_next  = pos_reg + COUNT_WIDTH'(1);
                end else if (rev) begin
                    step_next = 1'b1;
                    dir_next  = 1'b0;
                    pos_next  = pos_reg - COUNT_WIDTH'(1);
                end else if (illegal) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = '0;
            end
        endcase

        if (bus.clear) begin
            pos_next = '0;
            err_next = 1'b0;
        end
    end

    // State and output registers; prev tracks the filtered levels every cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            prev_reg     <= 2'b00;
            step_reg     <= 1'b0;
            dir_reg      <= 1'b0;
            pos_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            prev_reg     <= filt;
            step_reg     <= step_next;
            dir_reg      <= dir_next;
            pos_reg      <= pos_next;
            err_reg      <= err_next;
        end
    end

    assign bus.quad_a   = filt[1];
    assign bus.quad_b   = filt[0];
    assign bus.step     = step_reg;
    assign bus.dir      = dir_reg;
    assign bus.position = pos_reg;
    assign bus.error    = err_reg;
endmodule

// File: tb/tb_quadrature_filter.sv
// Directed bench for quadrature_filter: reset with pins high, forward and
// reverse decoding with latency, wrap, glitch rejection, illegal transitions,
// clear priority and mid-run reset. A 4-bit instance checks the signed wrap.
module tb_quadrature_filter;
    logic clk;
    logic resetn;

    int passes     = 0;
    int total      = 0;
    int step_seen  = 0;
    int a_high_seen = 0;

    quadrature_filter_if #(.COUNT_WIDTH(16)) bus ();
    quadrature_filter_if #(.COUNT_WIDTH(4))  bus_w ();

    quadrature_filter #(.FILTER_CYCLES(4), .COUNT_WIDTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    quadrature_filter #(.FILTER_CYCLES(4), .COUNT_WIDTH(4)) dut_w (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n clocks, sampling 1 ns after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.step === 1'b1) step_seen++;
            if (bus.quad_a === 1'b1) a_high_seen = 1;
        end
    endtask

    task automatic pins(input logic a, input logic b);
        bus.quad_a_pin = a;
        bus.quad_b_pin = b;
    endtask

    initial begin
        logic [1:0] fwd_seq [4];
        logic [1:0] lvl;
        fwd_seq[0] = 2'b10;
        fwd_seq[1] = 2'b11;
        fwd_seq[2] = 2'b01;
        fwd_seq[3] = 2'b00;

        resetn = 1'b0;
        bus.clear = 1'b0;
        pins(1'b1, 1'b1);
        bus_w.clear = 1'b0;
        bus_w.quad_a_pin = 1'b0;
        bus_w.quad_b_pin = 1'b0;
        run(2);

        // Reset state.
        check("rst_quad_a", bus.quad_a, 0);
        check("rst_quad_b", bus.quad_b, 0);
        check("rst_step", bus.step, 0);
        check("rst_dir", bus.dir, 0);
        check("rst_position", bus.position, 0);
        check("rst_error", bus.error, 0);
        $display("reset: outputs checked");

        // Pins high through reset: no false error or step after INIT.
        resetn = 1'b1;
        step_seen = 0;
        run(20);
        check("init_high_quad_a", bus.quad_a, 1);
        check("init_high_quad_b", bus.quad_b, 1);
        check("init_high_error", bus.error, 0);
        check("init_high_position", bus.position, 0);
        check("init_high_steps", step_seen, 0);
        $display("init with pins high: pos=%0h err=%0b", bus.position, bus.error);

        // Restart from 00.
        resetn = 1'b0;
        pins(1'b0, 1'b0);
        run(1);
        resetn = 1'b1;
        run(20);
        check("init_low_position", bus.position, 0);

        // Forward sequence with per-step latency of 2+F+1 clocks.
        for (int i = 0; i < 4; i++) begin
            lvl = fwd_seq[i];
            pins(lvl[1], lvl[0]);
            step_seen = 0;
            run(6);
            check("fwd_early_step", step_seen, 0);
            run(1);
            check("fwd_step", bus.step, 1);
            check("fwd_dir", bus.dir, 1);
            check("fwd_position", bus.position, i + 1);
            run(3);
            $display("forward step %0d: pos=%0h dir=%0b", i, bus.position, bus.dir);
        end
        check("fwd_single_pulse", step_seen, 1);

        // Clear, then one reverse step wraps 0 to 0xFFFF.
        bus.clear = 1'b1;
        run(1);
        bus.clear = 1'b0;
        check("clear_position", bus.position, 0);
        pins(1'b0, 1'b1);
        step_seen = 0;
        run(6);
        check("rev_early_step", step_seen, 0);
        run(1);
        check("rev_step", bus.step, 1);
        check("rev_dir", bus.dir, 0);
        check("rev_wrap_position", bus.position, 32'hFFFF);
        run(3);
        $display("reverse step: pos=%0h dir=%0b", bus.position, bus.dir);

        // 3-clock glitch on A is rejected.
        step_seen = 0;
        a_high_seen = 0;
        pins(1'b1, 1'b1);
        run(3);
        pins(1'b0, 1'b1);
        run(12);
        check("glitch3_steps", step_seen, 0);
        check("glitch3_quad_a", a_high_seen, 0);
        check("glitch3_position", bus.position, 32'hFFFF);
        $display("glitch 3 clocks: steps=%0d", step_seen);

        // 4-clock pulse on A passes: reverse then forward step.
        pins(1'b1, 1'b1);
        run(4);
        pins(1'b0, 1'b1);
        run(15);
        check("pulse4_quad_a", a_high_seen, 1);
        check("pulse4_steps", step_seen, 2);
        check("pulse4_position", bus.position, 32'hFFFF);
        check("pulse4_dir", bus.dir, 1);
        $display("pulse 4 clocks: steps=%0d pos=%0h", step_seen, bus.position);

        // Walk to position 2 at level 11, then jump both bits to 00.
        pins(1'b0, 1'b0);
        run(10);
        pins(1'b1, 1'b0);
        run(10);
        pins(1'b1, 1'b1);
        run(10);
        check("pre_err_position", bus.position, 2);
        step_seen = 0;
        pins(1'b0, 1'b0);
        run(15);
        check("illegal_error", bus.error, 1);
        check("illegal_position", bus.position, 2);
        check("illegal_steps", step_seen, 0);
        bus.clear = 1'b1;
        run(1);
        bus.clear = 1'b0;
        check("clear_error", bus.error, 0);
        check("clear_position2", bus.position, 0);
        $display("illegal then clear: err=%0b pos=%0h", bus.error, bus.position);

        // Five forward steps to position 5.
        for (int i = 0; i < 5; i++) begin
            lvl = fwd_seq[i % 4];
            pins(lvl[1], lvl[0]);
            run(10);
        end
        check("pre_clear_position", bus.position, 5);

        // Clear coincides with the decode of 10->11.
        pins(1'b1, 1'b1);
        run(6);
        check("pre_coincide_position", bus.position, 5);
        bus.clear = 1'b1;
        run(1);
        bus.clear = 1'b0;
        check("coincide_step", bus.step, 1);
        check("coincide_dir", bus.dir, 1);
        check("coincide_position", bus.position, 0);
        check("coincide_error", bus.error, 0);
        $display("clear with step: step=%0b pos=%0h", bus.step, bus.position);

        // Reset mid-sequence.
        pins(1'b0, 1'b1);
        run(3);
        resetn = 1'b0;
        run(1);
        check("midrst_quad_a", bus.quad_a, 0);
        check("midrst_quad_b", bus.quad_b, 0);
        check("midrst_step", bus.step, 0);
        check("midrst_dir", bus.dir, 0);
        check("midrst_position", bus.position, 0);
        check("midrst_error", bus.error, 0);
        resetn = 1'b1;
        step_seen = 0;
        run(20);
        check("reinit_steps", step_seen, 0);
        check("reinit_error", bus.error, 0);
        check("reinit_quad_b", bus.quad_b, 1);
        check("reinit_position", bus.position, 0);
        $display("mid-run reset: pos=%0h err=%0b", bus.position, bus.error);

        // 4-bit count: 7 forward steps reach 0x7, the 8th wraps to 0x8.
        for (int i = 0; i < 8; i++) begin
            lvl = fwd_seq[i % 4];
            bus_w.quad_a_pin = lvl[1];
            bus_w.quad_b_pin = lvl[0];
            run(8);
            if (i == 6) check("narrow_pos7", bus_w.position, 32'h7);
        end
        check("narrow_wrap", bus_w.position, 32'h8);
        check("narrow_dir", bus_w.dir, 1);
        $display("narrow wrap: pos=%0h", bus_w.position);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
